// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection
// and a saturating bubble counter.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              Hold_i,
    input  logic              Flush_i,
    input  logic              RegDst_i,
    input  logic              ALUSrc_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              RegWrite_i,
    input  logic              MemToReg_i,
    input  logic [1:0]        ALUOp_i,
    input  logic              UsesRt_i,
    input  logic [DATA_W-1:0] RSdata_i,
    input  logic [DATA_W-1:0] RTdata_i,
    input  logic [DATA_W-1:0] Imm_i,
    input  logic [4:0]        RSaddr_i,
    input  logic [4:0]        RTaddr_i,
    input  logic [4:0]        RDaddr_i,
    output logic              EX_RegDst_o,
    output logic              EX_ALUSrc_o,
    output logic              EX_MemRead_o,
    output logic              EX_MemWrite_o,
    output logic              EX_RegWrite_o,
    output logic              EX_MemToReg_o,
    output logic [1:0]        EX_ALUOp_o,
    output logic [DATA_W-1:0] EX_RSdata_o,
    output logic [DATA_W-1:0] EX_RTdata_o,
    output logic [DATA_W-1:0] EX_Imm_o,
    output logic [4:0]        EX_RSaddr_o,
    output logic [4:0]        EX_RTaddr_o,
    output logic [4:0]        EX_RDaddr_o,
    output logic              EX_Valid_o,
    output logic              Stall_o,
    output logic [CNT_W-1:0]  BubbleCnt_o
);

    logic              r_regdst;
    logic              r_alusrc;
    logic              r_memread;
    logic              r_memwrite;
    logic              r_regwrite;
    logic              r_memtoreg;
    logic [1:0]        r_aluop;
    logic [DATA_W-1:0] r_rsdata;
    logic [DATA_W-1:0] r_rtdata;
    logic [DATA_W-1:0] r_imm;
    logic [4:0]        r_rsaddr;
    logic [4:0]        r_rtaddr;
    logic [4:0]        r_rdaddr;
    logic              r_valid;
    logic [CNT_W-1:0]  r_cnt;

    logic w_rs_match;
    logic w_rt_match;
    logic w_stall;
    logic w_bubble;
    logic w_cnt_max;

    // A load in EX whose destination is read by the ID instruction cannot be
    // forwarded in time, so ID must wait one cycle.
    assign w_rs_match = (r_rtaddr == RSaddr_i);
    assign w_rt_match = UsesRt_i & (r_rtaddr == RTaddr_i);
    assign w_stall    = r_valid & r_memread & (r_rtaddr != 5'd0) & (w_rs_match | w_rt_match);
    assign w_bubble   = w_stall | Flush_i;
    assign w_cnt_max  = &r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_regdst   <= 1'b0;
            r_alusrc   <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_aluop    <= 2'b00;
            r_rsdata   <= '0;
            r_rtdata   <= '0;
            r_imm      <= '0;
            r_rsaddr   <= 5'd0;
            r_rtaddr   <= 5'd0;
            r_rdaddr   <= 5'd0;
            r_valid    <= 1'b0;
            r_cnt      <= '0;
        end else if (!Hold_i) begin
            r_rsdata <= RSdata_i;
            r_rtdata <= RTdata_i;
            r_imm    <= Imm_i;
            r_rsaddr <= RSaddr_i;
            r_rtaddr <= RTaddr_i;
            r_rdaddr <= RDaddr_i;
            if (w_bubble) begin
                r_regdst   <= 1'b0;
                r_alusrc   <= 1'b0;
                r_memread  <= 1'b0;
                r_memwrite <= 1'b0;
                r_regwrite <= 1'b0;
                r_memtoreg <= 1'b0;
                r_aluop    <= 2'b00;
                r_valid    <= 1'b0;
                if (!w_cnt_max) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_regdst   <= RegDst_i;
                r_alusrc   <= ALUSrc_i;
                r_memread  <= MemRead_i;
                r_memwrite <= MemWrite_i;
                r_regwrite <= RegWrite_i;
                r_memtoreg <= MemToReg_i;
                r_aluop    <= ALUOp_i;
                r_valid    <= 1'b1;
            end
        end
    end

    assign EX_RegDst_o   = r_regdst;
    assign EX_ALUSrc_o   = r_alusrc;
    assign EX_MemRead_o  = r_memread;
    assign EX_MemWrite_o = r_memwrite;
    assign EX_RegWrite_o = r_regwrite;
    assign EX_MemToReg_o = r_memtoreg;
    assign EX_ALUOp_o    = r_aluop;
    assign EX_RSdata_o   = r_rsdata;
    assign EX_RTdata_o   = r_rtdata;
    assign EX_Imm_o      = r_imm;
    assign EX_RSaddr_o   = r_rsaddr;
    assign EX_RTaddr_o   = r_rtaddr;
    assign EX_RDaddr_o   = r_rdaddr;
    assign EX_Valid_o    = r_valid;
    assign Stall_o       = w_stall;
    assign BubbleCnt_o   = r_cnt;

endmodule
